// File: rtl/vending_machine_if.sv
// Signal bundle between the coin/keypad front end, the vending controller and the actuators.
interface vending_machine_if #(
    parameter int NUM_ITEMS = 8,
    parameter int PRICE_W   = 8,
    parameter int INV_W     = 3,
    parameter int CREDIT_W  = 9
);
    logic [3:0]                   index;
    logic                         paymentMethod;
    logic [CREDIT_W-1:0]          creditBalance;
    logic                         nickel;
    logic                         dime;
    logic                         quarter;
    logic                         dollar;
    logic [NUM_ITEMS*PRICE_W-1:0] cost;
    logic                         cancel;
    logic [NUM_ITEMS*INV_W-1:0]   currentInventory;
    logic                         dispensed;
    logic [CREDIT_W-1:0]          change;
    logic [4:0]                   quart;
    logic [4:0]                   dim;
    logic [4:0]                   nick;

    modport master (
        output index, paymentMethod, creditBalance, nickel, dime, quarter, dollar,
               cost, cancel, currentInventory,
        input  dispensed, change, quart, dim, nick
    );

    modport slave (
        input  index, paymentMethod, creditBalance, nickel, dime, quarter, dollar,
               cost, cancel, currentInventory,
        output dispensed, change, quart, dim, nick
    );
endinterface

// File: rtl/vending_machine.sv
// Eight-slot vending controller with coin and card payment and greedy change split.
// Optional macro VM_CANCEL_EN enables coin refund on cancel; otherwise cancel is ignored.
module vending_machine #(
    parameter int NUM_ITEMS = 8,
    parameter int PRICE_W   = 8,
    parameter int INV_W     = 3,
    parameter int CREDIT_W  = 9
) (
    input logic             clk,
    input logic             rst,
    vending_machine_if.slave bus
);
    // state   | meaning
    // IDLE    | no credit held; card vends allowed
    // COLLECT | coin credit held, waiting for enough to vend
    // VEND    | dispense (or refund) cycle, change amount registered
    // CHANGE  | change split into coin counts
    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    localparam int                  SLOT_W      = $clog2(NUM_ITEMS);
    localparam logic [3:0]          NUM_ITEMS_L = 4'(NUM_ITEMS);
    localparam logic [CREDIT_W-1:0] CREDIT_MAX  = '1;

    state_t              state;
    logic [CREDIT_W-1:0] credit;
    logic [INV_W-1:0]    stock [NUM_ITEMS];
    logic                armed;
    logic [3:0]          prev_index;
    logic                prev_method;

    logic [7:0]          coin_val;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] coin_credit;
    logic [SLOT_W-1:0]   slot;
    logic                idx_valid;
    logic [PRICE_W-1:0]  price;
    logic [CREDIT_W-1:0] price_ext;
    logic [INV_W-1:0]    stock_cur;
    logic                in_stock;
    logic                arm_now;
    logic                coin_ok;
    logic                card_ok;
    logic                cancel_hit;
    logic [CREDIT_W-1:0] q_cnt;
    logic [CREDIT_W-1:0] rem25;
    logic [CREDIT_W-1:0] d_cnt;
    logic [CREDIT_W-1:0] rem10;
    logic [CREDIT_W-1:0] n_cnt;

    assign coin_val = (bus.nickel  ? 8'd5   : 8'd0) + (bus.dime   ? 8'd10  : 8'd0)
                    + (bus.quarter ? 8'd25  : 8'd0) + (bus.dollar ? 8'd100 : 8'd0);

    // Coins never exceed 140c per edge, so one extra bit is enough to detect overflow.
    assign credit_sum  = {1'b0, credit} + {{(CREDIT_W+1-8){1'b0}}, coin_val};
    assign credit_add  = credit_sum[CREDIT_W] ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
    assign coin_credit = {{(CREDIT_W-8){1'b0}}, coin_val};

    assign slot      = bus.index[SLOT_W-1:0];
    assign idx_valid = bus.index < NUM_ITEMS_L;
    assign price     = idx_valid ? bus.cost[slot*PRICE_W +: PRICE_W] : '0;
    assign price_ext = {{(CREDIT_W-PRICE_W){1'b0}}, price};
    assign stock_cur = stock[slot];
    assign in_stock  = idx_valid && (stock_cur != '0);

    // A card vend disarms until the selection or payment mode changes.
    assign arm_now = armed || (bus.index != prev_index) || (bus.paymentMethod != prev_method);
    assign coin_ok = bus.paymentMethod && in_stock && (credit >= price_ext);
    assign card_ok = !bus.paymentMethod && (state == IDLE) && arm_now && in_stock
                     && (bus.creditBalance >= price_ext);

`ifdef VM_CANCEL_EN
    assign cancel_hit = bus.cancel && (credit != '0);
`else
    logic unused_cancel;
    assign cancel_hit    = 1'b0;
    assign unused_cancel = bus.cancel;
`endif

    assign q_cnt = bus.change / CREDIT_W'(25);
    assign rem25 = bus.change % CREDIT_W'(25);
    assign d_cnt = rem25 / CREDIT_W'(10);
    assign rem10 = rem25 % CREDIT_W'(10);
    assign n_cnt = rem10 / CREDIT_W'(5);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            credit        <= '0;
            armed         <= 1'b1;
            prev_index    <= bus.index;
            prev_method   <= bus.paymentMethod;
            bus.dispensed <= 1'b0;
            bus.change    <= '0;
            bus.quart     <= '0;
            bus.dim       <= '0;
            bus.nick      <= '0;
            for (int i = 0; i < NUM_ITEMS; i++)
                stock[i] <= bus.currentInventory[i*INV_W +: INV_W];
        end else begin
            prev_index    <= bus.index;
            prev_method   <= bus.paymentMethod;
            armed         <= arm_now;
            bus.dispensed <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (cancel_hit) begin
                        bus.change <= credit_add;
                        credit     <= '0;
                        state      <= VEND;
                    end else if (coin_ok) begin
                        bus.dispensed <= 1'b1;
                        bus.change    <= credit - price_ext;
                        stock[slot]   <= stock_cur - INV_W'(1);
                        credit        <= coin_credit;
                        state         <= VEND;
                    end else if (card_ok) begin
                        bus.dispensed <= 1'b1;
                        bus.change    <= '0;
                        stock[slot]   <= stock_cur - INV_W'(1);
                        credit        <= coin_credit;
                        armed         <= 1'b0;
                        state         <= VEND;
                    end else begin
                        credit <= credit_add;
                        state  <= (credit_add != '0) ? COLLECT : IDLE;
                    end
                end
                VEND: begin
                    bus.quart <= q_cnt[4:0];
                    bus.dim   <= d_cnt[4:0];
                    bus.nick  <= n_cnt[4:0];
                    credit    <= credit_add;
                    state     <= CHANGE;
                end
                CHANGE: begin
                    credit <= credit_add;
                    state  <= (credit_add != '0) ? COLLECT : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vending_machine.sv
// Bench for vending_machine: directed scenarios plus random traffic against a cents-level model.
module tb_vending_machine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vending_machine_if vif ();
    vending_machine dut (.clk(clk), .rst(rst), .bus(vif));

`ifdef VM_CANCEL_EN
    localparam bit CANCEL_ON = 1'b1;
`else
    localparam bit CANCEL_ON = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    bit chk_on      = 1'b0;
    int disp_seen   = 0;

    // Model: credit in cents, per-slot stock, and which step of a vend is showing.
    int m_credit = 0, m_phase = 0, m_change = 0, m_quart = 0, m_dim = 0, m_nick = 0;
    int m_prev_idx = 0, m_prev_pm = 0;
    bit m_disp = 1'b0, m_held = 1'b0;
    int m_stock [8];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int price_of(int i);
        return int'(vif.cost[i*8 +: 8]);
    endfunction

    function automatic void model_step();
        int  coin, sum, pr, ix;
        bit  valid, ok, changed;
        coin = (vif.nickel ? 5 : 0) + (vif.dime ? 10 : 0) + (vif.quarter ? 25 : 0)
             + (vif.dollar ? 100 : 0);
        ix = int'(vif.index);
        if (rst) begin
            m_credit = 0; m_phase = 0; m_change = 0; m_quart = 0; m_dim = 0; m_nick = 0;
            m_disp = 1'b0; m_held = 1'b0;
            m_prev_idx = ix; m_prev_pm = int'(vif.paymentMethod);
            for (int i = 0; i < 8; i++) m_stock[i] = int'(vif.currentInventory[3*i +: 3]);
            return;
        end
        changed = (ix != m_prev_idx) || (int'(vif.paymentMethod) != m_prev_pm);
        m_prev_idx = ix;
        m_prev_pm  = int'(vif.paymentMethod);
        if (changed) m_held = 1'b0;
        sum = m_credit + coin;
        if (sum > 511) sum = 511;
        m_disp = 1'b0;
        case (m_phase)
            0: begin
                valid = ix < 8;
                pr    = valid ? price_of(ix) : 0;
                ok    = valid && (m_stock[ix & 7] > 0);
                if (CANCEL_ON && vif.cancel && m_credit > 0) begin
                    m_change = sum; m_credit = 0; m_phase = 1;
                end else if (vif.paymentMethod && ok && m_credit >= pr) begin
                    m_disp = 1'b1; m_change = m_credit - pr; m_stock[ix]--;
                    m_credit = coin; m_phase = 1;
                end else if (!vif.paymentMethod && m_credit == 0 && !m_held && ok
                             && int'(vif.creditBalance) >= pr) begin
                    m_disp = 1'b1; m_change = 0; m_stock[ix]--;
                    m_credit = coin; m_held = 1'b1; m_phase = 1;
                end else begin
                    m_credit = sum;
                end
            end
            1: begin
                m_quart = m_change / 25;
                m_dim   = (m_change % 25) / 10;
                m_nick  = ((m_change % 25) % 10) / 5;
                m_credit = sum; m_phase = 2;
            end
            default: begin
                m_credit = sum; m_phase = 0;
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("dispensed", 32'(vif.dispensed), 32'(m_disp));
            chk("change",    32'(vif.change),    m_change);
            chk("quart",     32'(vif.quart),     m_quart);
            chk("dim",       32'(vif.dim),       m_dim);
            chk("nick",      32'(vif.nick),      m_nick);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (vif.dispensed === 1'b1) disp_seen++;
    endtask

    task automatic set_coins(bit n, bit d, bit q, bit dl);
        vif.nickel = n; vif.dime = d; vif.quarter = q; vif.dollar = dl;
    endtask

    task automatic set_all(int price, int stk);
        for (int i = 0; i < 8; i++) begin
            vif.cost[8*i +: 8]             = 8'(price);
            vif.currentInventory[3*i +: 3] = 3'(stk);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        disp_seen = 0;
    endtask

    initial begin
        vif.index = 4'd2; vif.paymentMethod = 1'b1; vif.creditBalance = '0;
        vif.cancel = 1'b0;
        set_coins(0, 0, 0, 0);
        set_all(100, 4);
        tick();
        chk_on = 1'b1;
        reset_dut();

        // nickel+dollar on a 100c item: 5c change as one nickel
        set_coins(1, 0, 0, 1); tick();
        set_coins(0, 0, 0, 0); tick();
        chk("t1_dispensed", 32'(vif.dispensed), 1);
        chk("t1_change",    32'(vif.change), 5);
        tick();
        chk("t1_disp_drop", 32'(vif.dispensed), 0);
        chk("t1_quart", 32'(vif.quart), 0);
        chk("t1_dim",   32'(vif.dim), 0);
        chk("t1_nick",  32'(vif.nick), 1);
        tick();

        repeat (4) begin
            set_coins(1, 0, 0, 1); tick();
            set_coins(0, 0, 0, 0); repeat (3) tick();
        end
        chk("t2_vend_count",   disp_seen, 4);
        chk("t2_credit_model", m_credit, 105);
        chk("t2_stock_model",  m_stock[2], 0);

        // card: a held selection vends once, a new selection vends again
        vif.paymentMethod = 1'b0; vif.creditBalance = 9'd200; vif.index = 4'd1;
        reset_dut();
        repeat (4) tick();
        chk("t3_held_vends", disp_seen, 1);
        chk("t3_change",     32'(vif.change), 0);
        vif.index = 4'd3;
        repeat (4) tick();
        chk("t3_reselect_vends", disp_seen, 2);

        vif.creditBalance = 9'd50; vif.index = 4'd0;
        reset_dut();
        repeat (4) tick();
        chk("t4_low_balance", disp_seen, 0);

        vif.paymentMethod = 1'b1; vif.index = 4'd2;
        reset_dut();
        set_coins(0, 0, 1, 0); repeat (3) tick();
        set_coins(0, 0, 0, 0); vif.cancel = 1'b1; tick();
        vif.cancel = 1'b0;
`ifdef VM_CANCEL_EN
        chk("t5_refund_change", 32'(vif.change), 75);
        chk("t5_refund_nodisp", 32'(vif.dispensed), 0);
        tick();
        chk("t5_refund_quart", 32'(vif.quart), 3);
        chk("t5_refund_dim",   32'(vif.dim), 0);
`else
        tick();
        chk("t5_credit_kept",  m_credit, 75);
        chk("t5_change_clear", 32'(vif.change), 0);
`endif
        chk("t5_no_dispense", disp_seen, 0);

        // 490c banked on an invalid slot, then a 15c item
        set_all(15, 4); vif.index = 4'd9;
        reset_dut();
        set_coins(0, 0, 0, 1); repeat (4) tick();
        set_coins(0, 0, 1, 0); repeat (3) tick();
        set_coins(1, 1, 0, 0); tick();
        set_coins(0, 0, 0, 0); vif.index = 4'd5; tick();
        chk("t6_dispensed", 32'(vif.dispensed), 1);
        chk("t6_change",    32'(vif.change), 475);
        tick();
        chk("t6_quart", 32'(vif.quart), 19);
        chk("t6_dim",   32'(vif.dim), 0);
        chk("t6_nick",  32'(vif.nick), 0);

        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) begin
                for (int i = 0; i < 8; i++) begin
                    vif.cost[8*i +: 8]             = 8'($urandom_range(5, 255));
                    vif.currentInventory[3*i +: 3] = 3'($urandom_range(0, 7));
                end
            end
            if ($urandom_range(0, 3) == 0) vif.index = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 19) == 0) vif.paymentMethod = ~vif.paymentMethod;
            if ($urandom_range(0, 7) == 0) vif.creditBalance = 9'($urandom_range(0, 511));
            set_coins($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
            vif.cancel = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
